// File: rtl/pulse_width_meter.sv
// pulse_width_meter
//   Measures the width, in clock cycles, of each complete high pulse on a
//   delayed serial bit and hands every width to a reader through a
//   single-entry valid/ready holding register. A free-running counter
//   tallies falling-edge strobes from the upstream shift/edge stage.
//
// Ports
//   clock        single clock, all logic on posedge
//   reset        asynchronous, active-high
//   sig_in       serial level (sig_d of the shift stage)
//   edge_in      one-cycle falling-edge strobe (new_signal)
//   width_out    measured high-pulse width in cycles
//   width_valid  width_out holds an unread measurement
//   width_ready  reader accepts width_out this cycle
//   saturated    the measurement in width_out hit 2^WIDTH_W-1
//   overrun      sticky: a completed measurement was dropped
//   edge_count   number of edge_in strobes seen (wraps)
//
// Build option
//   PULSE_WIDTH_METER_OVERRUN_EN  when defined, overrun is set on a dropped
//   completion and held until reset; otherwise overrun is tied low.

module pulse_width_meter #(
  parameter int unsigned WIDTH_W = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sig_in,
  input  logic               edge_in,
  output logic [WIDTH_W-1:0] width_out,
  output logic               width_valid,
  input  logic               width_ready,
  output logic               saturated,
  output logic               overrun,
  output logic [CNT_W-1:0]   edge_count
);

  localparam logic [WIDTH_W-1:0] RUN_MAX = '1;
  localparam logic [WIDTH_W-1:0] RUN_ONE = WIDTH_W'(1);

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [WIDTH_W-1:0] run_cnt;
  logic               run_sat;

  logic start_c;
  logic extend_c;
  logic complete_c;
  logic load_c;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_ARM;
    else       state <= next_state;
  end

  // Next-state logic; ARM swallows a pulse already high at reset release
  always_comb begin
    next_state = state;
    case (state)
      ST_ARM:     if (!sig_in) next_state = ST_IDLE;
      ST_IDLE:    if (sig_in)  next_state = ST_MEASURE;
      ST_MEASURE: if (!sig_in) next_state = ST_IDLE;
      default:    next_state = ST_ARM;
    endcase
  end

  // Control strobes; the slot is free when empty or being read this cycle
  always_comb begin
    start_c    = 1'b0;
    extend_c   = 1'b0;
    complete_c = 1'b0;
    case (state)
      ST_IDLE:    start_c = sig_in;
      ST_MEASURE: begin
        extend_c   = sig_in;
        complete_c = !sig_in;
      end
      default: ;
    endcase
    load_c = complete_c && (!width_valid || width_ready);
  end

  // Run counter, saturating at RUN_MAX
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
      run_sat <= 1'b0;
    end else if (start_c) begin
      run_cnt <= RUN_ONE;
      run_sat <= (RUN_ONE == RUN_MAX);
    end else if (extend_c && (run_cnt != RUN_MAX)) begin
      run_cnt <= run_cnt + RUN_ONE;
      if (run_cnt == RUN_MAX - RUN_ONE) run_sat <= 1'b1;
    end
  end

  // Holding register; a load wins over a simultaneous read
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      width_out   <= '0;
      saturated   <= 1'b0;
      width_valid <= 1'b0;
    end else if (load_c) begin
      width_out   <= run_cnt;
      saturated   <= run_sat;
      width_valid <= 1'b1;
    end else if (width_valid && width_ready) begin
      width_valid <= 1'b0;
    end
  end

`ifdef PULSE_WIDTH_METER_OVERRUN_EN
  logic drop_c;
  assign drop_c = complete_c && width_valid && !width_ready;

  // Sticky drop indicator
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       overrun <= 1'b0;
    else if (drop_c) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

  // Free-running edge strobe counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        edge_count <= '0;
    else if (edge_in) edge_count <= edge_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Self-checking bench for pulse_width_meter (WIDTH_W=4, CNT_W=16).
module tb_pulse_width_meter;

  localparam int unsigned WIDTH_W = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int          WMAX    = (1 << WIDTH_W) - 1;

`ifdef PULSE_WIDTH_METER_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               sig_in = 1'b0;
  logic               edge_in = 1'b0;
  logic               width_ready = 1'b0;
  logic [WIDTH_W-1:0] width_out;
  logic               width_valid;
  logic               saturated;
  logic               overrun;
  logic [CNT_W-1:0]   edge_count;

  pulse_width_meter #(.WIDTH_W(WIDTH_W), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .sig_in     (sig_in),
    .edge_in    (edge_in),
    .width_out  (width_out),
    .width_valid(width_valid),
    .width_ready(width_ready),
    .saturated  (saturated),
    .overrun    (overrun),
    .edge_count (edge_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural reference: pulse bookkeeping in plain integers
  bit m_armed;
  int m_run;
  bit m_valid;
  int m_width;
  bit m_sat;
  bit m_ovr;
  int m_edges;

  task automatic model_reset();
    m_armed = 0; m_run = 0; m_valid = 0; m_width = 0;
    m_sat = 0; m_ovr = 0; m_edges = 0;
  endtask

  task automatic model_step(input bit s, input bit r, input bit e);
    bit consumed, load;
    consumed = m_valid && r;
    load = 0;
    m_edges = (m_edges + int'(e)) % (1 << CNT_W);
    if (!m_armed) begin
      if (!s) m_armed = 1;
    end else if (s) begin
      m_run++;
    end else if (m_run > 0) begin
      if (!m_valid || r) begin
        load = 1;
        m_width = (m_run > WMAX) ? WMAX : m_run;
        m_sat = (m_run >= WMAX);
      end else if (OVR_EN) begin
        m_ovr = 1;
      end
      m_run = 0;
    end
    if (load) m_valid = 1;
    else if (consumed) m_valid = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".width_valid"}, int'(width_valid), int'(m_valid));
    chk({tag, ".width_out"},   int'(width_out),   m_width);
    chk({tag, ".saturated"},   int'(saturated),   int'(m_sat));
    chk({tag, ".overrun"},     int'(overrun),     int'(m_ovr));
    chk({tag, ".edge_count"},  int'(edge_count),  m_edges);
  endtask

  // One clock: drive, step the model at the edge, settle past the edge
  task automatic cyc(input bit s, input bit r, input bit e);
    sig_in = s; width_ready = r; edge_in = e;
    @(posedge clock);
    model_step(s, r, e);
    #1;
  endtask

  task automatic do_reset(input bit s);
    @(negedge clock);
    sig_in = s; width_ready = 1'b0; edge_in = 1'b0;
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    bit         sig;
    bit         rdy;
    bit         exp_valid;
    logic [3:0] exp_width;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Reset while high, ARM discards it, then 3-cycle and 1-cycle pulses
    for (int i = 0; i < 5; i++) vecs.push_back('{1, 1, 0, 4'd0});
    vecs.push_back('{0, 1, 0, 4'd0});
    for (int i = 0; i < 3; i++) vecs.push_back('{1, 1, 0, 4'd0});
    vecs.push_back('{0, 1, 1, 4'd3});
    vecs.push_back('{0, 1, 0, 4'd3});
    vecs.push_back('{1, 1, 0, 4'd3});
    vecs.push_back('{0, 1, 1, 4'd1});
    vecs.push_back('{0, 1, 0, 4'd1});

    do_reset(1'b1);
    chk("reset.width_valid", int'(width_valid), 0);
    chk("reset.width_out",   int'(width_out),   0);
    chk("reset.edge_count",  int'(edge_count),  0);

    foreach (vecs[i]) begin
      cyc(vecs[i].sig, vecs[i].rdy, 1'b0);
      chk($sformatf("vec%0d.width_valid", i), int'(width_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.width_out", i),   int'(width_out),   int'(vecs[i].exp_width));
    end
    chk_model("vec_end");

    // 20-cycle pulse saturates at 15
    for (int i = 0; i < 20; i++) cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("sat.width_valid", int'(width_valid), 1);
    chk("sat.width_out",   int'(width_out),   15);
    chk("sat.saturated",   int'(saturated),   1);
    cyc(0, 1, 0);
    chk("sat.drain_valid", int'(width_valid), 0);
    chk("sat.hold_sat",    int'(saturated),   1);

    // Reader stalled: width 2 held, width 4 dropped
    do_reset(1'b0);
    cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
    chk("stall.first_valid", int'(width_valid), 1);
    chk("stall.first_width", int'(width_out),   2);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("stall.held_width", int'(width_out),   2);
    chk("stall.held_sat",   int'(saturated),   0);
    chk("stall.overrun",    int'(overrun),     int'(OVR_EN));
    cyc(0, 1, 0);
    chk("stall.drain_valid", int'(width_valid), 0);
    chk("stall.overrun_sticky", int'(overrun), int'(OVR_EN));

    // Completion coincides with the read of the previous value
    do_reset(1'b0);
    cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
    chk("coin.pre_width", int'(width_out), 2);
    cyc(0, 1, 0);
    chk("coin.width_valid", int'(width_valid), 1);
    chk("coin.width_out",   int'(width_out),   3);
    chk("coin.overrun",     int'(overrun),     0);
    cyc(0, 1, 0);
    chk("coin.drain_valid", int'(width_valid), 0);

    // Randomized runs against the reference model
    do_reset(1'b0);
    begin
      bit lvl;
      lvl = 0;
      for (int p = 0; p < 150; p++) begin
        int len;
        len = int'($urandom_range(1, 20));
        for (int k = 0; k < len; k++) begin
          cyc(lvl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          chk_model($sformatf("rand%0d", p));
        end
        lvl = !lvl;
      end
    end

    // Edge counter wraps modulo 2^16
    do_reset(1'b0);
    for (int i = 0; i < 70000; i++) cyc(0, 1, 1);
    cyc(0, 1, 0);
    chk("edges.count", int'(edge_count), 4464);
    chk_model("edges");

    // Reset mid-pulse with a pending measurement clears everything at once
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
    cyc(1, 0, 1); cyc(1, 0, 1);
    chk("midrst.pre_valid", int'(width_valid), 1);
    reset = 1'b1;
    model_reset();
    #1;
    chk_model("midrst");
    @(negedge clock);
    reset = 1'b0;
    sig_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
